matmul_sequencer: RTL
=====================

MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

Interface
REQ-001 Parameters: none; the element width is fixed at 3 bits, the result width at 7 bits and the step count at 8.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset, with ports as follows.
- clk  input  1  clock; all state updates occur on the rising edge.
- rst_n  input  1  asynchronous reset, active low.
REQ-003 start  input  1  request to multiply; sampled only in IDLE.
REQ-004 matrixA  input  12  operand A, row-major [[a0,a1],[a2,a3]]; a0=[2:0], a1=[5:3], a2=[8:6], a3=[11:9].
REQ-005 matrixB  input  12  operand B, same packing with elements b0..b3.
REQ-006 ack  input  1  consumer accepts the result; honoured only in DONE.
REQ-007 busy  output  1  high in RUN and DONE.
REQ-008 entry_out  output  4  current step index 0..7 in RUN; 4'd8 otherwise.
REQ-009 result  output  28  packed C: c00=[6:0], c01=[13:7], c10=[20:14], c11=[27:21].
REQ-010 valid  output  1  result is complete and stable.

Function
REQ-011 The FSM SHALL have the states IDLE, RUN and DONE, with the following transitions.
- IDLE->RUN when start=1.
- RUN->DONE after step 7.
- DONE->IDLE when ack=1.
REQ-012 On the IDLE edge with start=1, the block SHALL latch matrixA and matrixB into internal registers, clear the step counter to 0 and clear result to 0; later input changes SHALL have no effect until the next IDLE.
REQ-013 In RUN, the block SHALL form one 3x3->6-bit product per cycle using a single multiplier, with the operand pair for steps 0..7 as follows.
- A: a0,a1,a0,a1,a2,a3,a2,a3.
- B: b0,b2,b1,b3,b0,b2,b1,b3.
REQ-014 On even steps, the block SHALL load the 7-bit accumulator with the product.
REQ-015 On odd step k, the block SHALL write accumulator+product to result element k>>1 (c00, c01, c10, c11 in order).
REQ-016 The block SHALL perform all arithmetic unsigned with 7-bit sums; the maximum of 98 SHALL fit without overflow.
REQ-017 Latency SHALL be as follows, with start sampled at edge T:
- RUN occupies edges T+1..T+8;
- valid rises after edge T+8;
- the first possible result SHALL therefore be visible 9 cycles after start.
REQ-018 valid SHALL be 1 only in DONE, and result SHALL be held constant while valid=1.
REQ-019 ack=1 in DONE SHALL return the block to IDLE on that edge; valid SHALL drop and result SHALL keep its value until the next accepted start.
REQ-020 start in RUN or DONE SHALL be ignored and not queued; ack outside DONE SHALL be ignored.
REQ-021 Simultaneous ack and start in DONE: ack SHALL take effect, and start SHALL be ignored that cycle (a new request is accepted only from IDLE).
REQ-022 The step counter SHALL NOT wrap inside RUN; it SHALL leave RUN exactly after step 7.

Reset
REQ-023 rst_n=0 SHALL, asynchronously and at any time including mid-RUN, force the following values.
- State: IDLE.
- busy=0, valid=0.
- entry_out=8.
- result=0.
- Accumulator and latched operands: 0.
REQ-024 After rst_n rises, the block SHALL accept start on the first rising edge.

Configuration
REQ-025 When the macro MATMUL_ABORT_EN is defined, the block SHALL have an input port abort (1 bit).
- abort=1 in RUN SHALL return the block to IDLE on that edge with result cleared to 0 and valid never asserted.
- abort in IDLE or DONE SHALL be ignored.
REQ-026 When MATMUL_ABORT_EN is undefined, the abort port SHALL NOT exist and RUN SHALL always complete all 8 steps.

Verification
REQ-027 Identity case: A=12'h201, B=12'hB1A, start pulse -> valid after 9 cycles with c00=2, c01=3, c10=4, c11=5.
REQ-028 General case: A=12'h8D1, B=12'h1F5 -> c00=19, c01=6, c10=43, c11=18, with entry_out stepping 0..7 on consecutive cycles.
REQ-029 Maximum case: A=B=12'hFFF -> every element equals 98, with no wrap.
REQ-030 Handshake: hold ack=0 for 5 cycles in DONE -> valid and result remain stable; pulse start in RUN and DONE -> ignored; ack=1 with start=1 -> IDLE and no new run.
REQ-031 Reset: assert rst_n=0 at step 4 -> immediate IDLE with all outputs at reset values; a fresh start then produces a correct result.
REQ-032 With MATMUL_ABORT_EN defined: abort at step 3 -> IDLE next edge, valid stays 0 and result=0.

Source files
------------

// File: rtl/matmul_sequencer.sv
// Sequential 2x2 matrix multiplier (3-bit elements, 7-bit results) using one shared multiplier over 8 steps.
// Optional abort input enabled by defining MATMUL_ABORT_EN.
module matmul_sequencer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [11:0] matrixA,
   input  logic [11:0] matrixB,
   input  logic        ack,
`ifdef MATMUL_ABORT_EN
   input  logic        abort,
`endif
   output logic        busy,
   output logic [3:0]  entry_out,
   output logic [27:0] result,
   output logic        valid
);

   // Handshake: start is taken only in IDLE (never queued); valid is high only in DONE with
   // result frozen; ack is honoured only in DONE and wins over a simultaneous start.
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state_q, state_d;
   logic [2:0]  step_q;
   logic [11:0] a_q, b_q;
   logic [6:0]  acc_q;
   logic [27:0] result_q;
   logic [2:0]  op_a, op_b;
   logic [5:0]  product;
   logic [6:0]  sum;
   logic        abort_req;

`ifdef MATMUL_ABORT_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif

   function automatic logic [2:0] pick(input logic [11:0] m, input logic [1:0] idx);
      logic [2:0] e;
      case (idx)
         2'd0:    e = m[2:0];
         2'd1:    e = m[5:3];
         2'd2:    e = m[8:6];
         default: e = m[11:9];
      endcase
      return e;
   endfunction

   // Step bits map directly to operand indices: A = {s2,s0}, B = {s0,s1}.
   always_comb begin
      op_a    = pick(a_q, {step_q[2], step_q[0]});
      op_b    = pick(b_q, {step_q[0], step_q[1]});
      product = {3'b000, op_a} * {3'b000, op_b};
      sum     = acc_q + {1'b0, product};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start) state_d = RUN;
         RUN: begin
            if (abort_req)          state_d = IDLE;
            else if (step_q == 3'd7) state_d = DONE;
         end
         DONE: if (ack) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q      <= '0;
         b_q      <= '0;
         step_q   <= '0;
         acc_q    <= '0;
         result_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  a_q      <= matrixA;
                  b_q      <= matrixB;
                  step_q   <= '0;
                  acc_q    <= '0;
                  result_q <= '0;
               end
            end
            RUN: begin
               if (abort_req) begin
                  step_q   <= '0;
                  acc_q    <= '0;
                  result_q <= '0;
               end else begin
                  // Counter rolls to 0 only on the step that also leaves RUN.
                  step_q <= step_q + 3'd1;
                  if (!step_q[0]) begin
                     acc_q <= {1'b0, product};
                  end else begin
                     case (step_q[2:1])
                        2'd0:    result_q[6:0]   <= sum;
                        2'd1:    result_q[13:7]  <= sum;
                        2'd2:    result_q[20:14] <= sum;
                        default: result_q[27:21] <= sum;
                     endcase
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign busy      = (state_q != IDLE);
   assign valid     = (state_q == DONE);
   assign entry_out = (state_q == RUN) ? {1'b0, step_q} : 4'd8;
   assign result    = result_q;

endmodule
